// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding pipeline tracker: register width,
// FSM encoding and the per-stage destination record.
package hazard_pkg;

   localparam int unsigned REG_W = 4;
   localparam logic [REG_W-1:0] ZERO_REG = '0;

   typedef enum logic {
      RUN  = 1'b0,
      WAIT = 1'b1
   } state_t;

   typedef struct packed {
      logic [REG_W-1:0] rd;
      logic             regWrite;
      logic             memRead;
   } pipe_entry_t;

   localparam pipe_entry_t BUBBLE = '0;

endpackage

// File: rtl/hazard_pipe_tracker_if.sv
// Bundle between the ID stage / data memory and the forwarding producer.
interface hazard_pipe_tracker_if
   import hazard_pkg::*;
#(
   parameter int unsigned CNT_W = 16
);

   logic             id_valid;
   logic [REG_W-1:0] id_rd;
   logic             id_regWrite;
   logic             id_memRead;
   logic [REG_W-1:0] id_rs;
   logic [REG_W-1:0] id_rt;
   logic             flush;
   logic             mem_ready;

   logic [REG_W-1:0] ID_EX_rd;
   logic [REG_W-1:0] EX_MEM_rd;
   logic [REG_W-1:0] MEM_WB_rd;
   logic             ID_EX_regWrite;
   logic             EX_MEM_regWrite;
   logic             MEM_WB_regWrite;
   logic             ID_EX_memRead;
   logic             EX_MEM_memRead;
   logic             stall_id;
   logic             mem_wait;
   logic             mem_error;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output id_valid, id_rd, id_regWrite, id_memRead, id_rs, id_rt, flush, mem_ready,
      input  ID_EX_rd, EX_MEM_rd, MEM_WB_rd,
      input  ID_EX_regWrite, EX_MEM_regWrite, MEM_WB_regWrite,
      input  ID_EX_memRead, EX_MEM_memRead,
      input  stall_id, mem_wait, mem_error, stall_count
   );

   modport slave (
      input  id_valid, id_rd, id_regWrite, id_memRead, id_rs, id_rt, flush, mem_ready,
      output ID_EX_rd, EX_MEM_rd, MEM_WB_rd,
      output ID_EX_regWrite, EX_MEM_regWrite, MEM_WB_regWrite,
      output ID_EX_memRead, EX_MEM_memRead,
      output stall_id, mem_wait, mem_error, stall_count
   );

endinterface

// File: rtl/pipe_stage_reg.sv
// One pipeline register of destination metadata; hold wins over bubble insertion.
module pipe_stage_reg
   import hazard_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        hold,
   input  logic        load_bubble,
   input  pipe_entry_t d,
   output pipe_entry_t q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)            q <= BUBBLE;
      else if (!hold)       q <= load_bubble ? BUBBLE : d;
   end

endmodule

// File: rtl/hazard_pipe_tracker.sv
// Tracks rd/regWrite/memRead through ID/EX, EX/MEM, MEM/WB; handles load-use
// bubbles and freezes on outstanding loads with a timeout.
module hazard_pipe_tracker
   import hazard_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned CNT_W       = 16
)(
   input logic                  clk,
   input logic                  reset,
   hazard_pipe_tracker_if.slave bus
);

   localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT + 1);

   state_t            state, state_nxt;
   logic [WCNT_W-1:0] wait_cnt, wait_cnt_nxt;
   logic              flush_pend, flush_pend_nxt;
   logic              mem_error, mem_error_nxt;
   logic [CNT_W-1:0]  stall_count;

   pipe_entry_t id_entry, id_ex, ex_mem, mem_wb;
   logic        freeze, load_use, timeout, id_bubble, stall_id;
   logic        unused_mem_wb_load;

   always_comb begin
      timeout  = (state == WAIT) && !bus.mem_ready && (wait_cnt == WCNT_W'(MEM_TIMEOUT));
      freeze   = ((state == RUN) && ex_mem.memRead && !bus.mem_ready) ||
                 ((state == WAIT) && !bus.mem_ready && (wait_cnt != WCNT_W'(MEM_TIMEOUT)));
      load_use = bus.id_valid && id_ex.memRead && (id_ex.rd != ZERO_REG) &&
                 ((id_ex.rd == bus.id_rs) || (id_ex.rd == bus.id_rt));
      stall_id  = freeze || load_use;
      id_bubble = bus.flush || flush_pend || load_use || !bus.id_valid;
      id_entry  = '{rd:       bus.id_rd,
                    regWrite: bus.id_regWrite && (bus.id_rd != ZERO_REG),
                    memRead:  bus.id_memRead};
   end

   // Next-state logic for the memory-wait FSM and its side registers
   always_comb begin
      state_nxt      = state;
      wait_cnt_nxt   = wait_cnt;
      flush_pend_nxt = flush_pend;
      mem_error_nxt  = mem_error;
      case (state)
         RUN: begin
            if (freeze) begin
               state_nxt    = WAIT;
               wait_cnt_nxt = WCNT_W'(1);
            end
         end
         WAIT: begin
            if (bus.mem_ready) begin
               state_nxt    = RUN;
               wait_cnt_nxt = '0;
            end else if (timeout) begin
               state_nxt     = RUN;
               wait_cnt_nxt  = '0;
               mem_error_nxt = 1'b1;
            end else begin
               wait_cnt_nxt = wait_cnt + WCNT_W'(1);
            end
         end
         default: begin
            state_nxt    = RUN;
            wait_cnt_nxt = '0;
         end
      endcase
      if (freeze) flush_pend_nxt = flush_pend || bus.flush;
      else        flush_pend_nxt = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= RUN;
         wait_cnt   <= '0;
         flush_pend <= 1'b0;
         mem_error  <= 1'b0;
      end else begin
         state      <= state_nxt;
         wait_cnt   <= wait_cnt_nxt;
         flush_pend <= flush_pend_nxt;
         mem_error  <= mem_error_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                 stall_count <= '0;
      else if (stall_id && (stall_count != '1))  stall_count <= stall_count + CNT_W'(1);
   end

   pipe_stage_reg u_id_ex (
      .clk(clk), .reset(reset), .hold(freeze), .load_bubble(id_bubble),
      .d(id_entry), .q(id_ex)
   );

   pipe_stage_reg u_ex_mem (
      .clk(clk), .reset(reset), .hold(freeze), .load_bubble(1'b0),
      .d(id_ex), .q(ex_mem)
   );

   // An abandoned load must not write back
   pipe_stage_reg u_mem_wb (
      .clk(clk), .reset(reset), .hold(freeze), .load_bubble(timeout),
      .d(ex_mem), .q(mem_wb)
   );

   assign unused_mem_wb_load  = mem_wb.memRead;

   assign bus.ID_EX_rd        = id_ex.rd;
   assign bus.EX_MEM_rd       = ex_mem.rd;
   assign bus.MEM_WB_rd       = mem_wb.rd;
   assign bus.ID_EX_regWrite  = id_ex.regWrite;
   assign bus.EX_MEM_regWrite = ex_mem.regWrite;
   assign bus.MEM_WB_regWrite = mem_wb.regWrite;
   assign bus.ID_EX_memRead   = id_ex.memRead;
   assign bus.EX_MEM_memRead  = ex_mem.memRead;
   assign bus.stall_id        = stall_id;
   assign bus.mem_wait        = (state == WAIT);
   assign bus.mem_error       = mem_error;
   assign bus.stall_count     = stall_count;

endmodule

// File: tb/tb_hazard_pipe_tracker.sv
// Scoreboard bench: driver pushes model predictions, negedge monitor compares.
module tb_hazard_pipe_tracker;
   import hazard_pkg::*;

   localparam int unsigned TO    = 15;
   localparam int unsigned CNT_W = 16;
   localparam int          CMAX  = 65535;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   hazard_pipe_tracker_if #(.CNT_W(CNT_W)) bus ();

   hazard_pipe_tracker #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   typedef struct {int rd; bit rw; bit mr;} ent_t;
   typedef struct {bit stall; ent_t st[3]; bit mw; bit err; int cnt;} exp_t;

   exp_t sb[$];
   ent_t m[3];
   bit   m_wait, m_err, m_fpend;
   int   m_wcnt, m_cnt;
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) m[i] = '{0, 1'b0, 1'b0};
      m_wait = 0; m_err = 0; m_fpend = 0; m_wcnt = 0; m_cnt = 0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, ".ID_EX_rd"},  int'(bus.ID_EX_rd), 0);
      chk({tag, ".EX_MEM_rd"}, int'(bus.EX_MEM_rd), 0);
      chk({tag, ".MEM_WB_rd"}, int'(bus.MEM_WB_rd), 0);
      chk({tag, ".regWrite"},  int'({bus.ID_EX_regWrite, bus.EX_MEM_regWrite, bus.MEM_WB_regWrite}), 0);
      chk({tag, ".memRead"},   int'({bus.ID_EX_memRead, bus.EX_MEM_memRead}), 0);
      chk({tag, ".mem_wait"},  int'(bus.mem_wait), 0);
      chk({tag, ".mem_error"}, int'(bus.mem_error), 0);
      chk({tag, ".stall_id"},  int'(bus.stall_id), 0);
      chk({tag, ".stall_count"}, int'(bus.stall_count), 0);
   endtask

   // Apply one cycle of stimulus, predict what is visible this cycle, then advance the model
   task automatic step(input bit v, input int rd, input bit rw, input bit mr,
                       input int rs, input int rt, input bit fl, input bit rdy);
      exp_t e;
      bit ld_wait, expired, frz, lu;
      bus.id_valid    = v;
      bus.id_rd       = 4'(rd);
      bus.id_regWrite = rw;
      bus.id_memRead  = mr;
      bus.id_rs       = 4'(rs);
      bus.id_rt       = 4'(rt);
      bus.flush       = fl;
      bus.mem_ready   = rdy;

      ld_wait = m[1].mr && !rdy;
      expired = m_wait && (m_wcnt == TO);
      frz     = ld_wait && !expired;
      lu      = v && m[0].mr && (m[0].rd != 0) && (m[0].rd == rs || m[0].rd == rt);

      e.stall = frz || lu;
      e.st    = m;
      e.mw    = m_wait;
      e.err   = m_err;
      e.cnt   = m_cnt;
      sb.push_back(e);

      if ((frz || lu) && m_cnt < CMAX) m_cnt++;
      if (frz) begin
         if (fl) m_fpend = 1;
         m_wcnt = m_wait ? m_wcnt + 1 : 1;
         m_wait = 1;
      end else begin
         if (ld_wait) m_err = 1;
         m[2] = ld_wait ? '{0, 1'b0, 1'b0} : m[1];
         m[1] = m[0];
         if (fl || m_fpend || lu || !v) m[0] = '{0, 1'b0, 1'b0};
         else                           m[0] = '{rd, rw && (rd != 0), mr};
         m_fpend = 0; m_wait = 0; m_wcnt = 0;
      end
      @(posedge clk); #1;
   endtask

   task automatic nop(input bit rdy);
      step(1'b0, 0, 1'b0, 1'b0, 0, 0, 1'b0, rdy);
   endtask

   // Monitor: every cycle the DUT presents its state, compare against the oldest prediction
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("stall_id",        int'(bus.stall_id),        int'(e.stall));
            chk("ID_EX_rd",        int'(bus.ID_EX_rd),        e.st[0].rd);
            chk("ID_EX_regWrite",  int'(bus.ID_EX_regWrite),  int'(e.st[0].rw));
            chk("ID_EX_memRead",   int'(bus.ID_EX_memRead),   int'(e.st[0].mr));
            chk("EX_MEM_rd",       int'(bus.EX_MEM_rd),       e.st[1].rd);
            chk("EX_MEM_regWrite", int'(bus.EX_MEM_regWrite), int'(e.st[1].rw));
            chk("EX_MEM_memRead",  int'(bus.EX_MEM_memRead),  int'(e.st[1].mr));
            chk("MEM_WB_rd",       int'(bus.MEM_WB_rd),       e.st[2].rd);
            chk("MEM_WB_regWrite", int'(bus.MEM_WB_regWrite), int'(e.st[2].rw));
            chk("mem_wait",        int'(bus.mem_wait),        int'(e.mw));
            chk("mem_error",       int'(bus.mem_error),       int'(e.err));
            chk("stall_count",     int'(bus.stall_count),     e.cnt);
         end
      end
   end

   initial begin
      int  burst;
      bit  rdy;
      reset = 1'b1;
      bus.id_valid = 0; bus.id_rd = '0; bus.id_regWrite = 0; bus.id_memRead = 0;
      bus.id_rs = '0; bus.id_rt = '0; bus.flush = 0; bus.mem_ready = 0;
      model_reset();
      #12;
      check_all_zero("reset");
      @(posedge clk); #1;
      reset = 1'b0;

      // load r3 then a use of r3: one bubble
      step(1, 3, 1, 1, 0, 0, 0, 1);
      step(1, 7, 1, 0, 3, 0, 0, 1);
      step(1, 7, 1, 0, 3, 0, 0, 1);
      nop(1); nop(1); nop(1);

      // load r5 with memory slow for 3 cycles
      step(1, 5, 1, 1, 0, 0, 0, 1);
      nop(1);
      nop(0); nop(0); nop(0);
      nop(1); nop(1); nop(1);

      // load r6 never answered: timeout drops it
      step(1, 6, 1, 1, 0, 0, 0, 1);
      nop(1);
      for (int i = 0; i < 16; i++) nop(0);
      nop(1); nop(1); nop(1);

      // flush during WAIT squashes the held ID instruction
      step(1, 2, 1, 1, 0, 0, 0, 1);
      step(1, 8, 1, 0, 0, 0, 0, 1);
      step(1, 9, 1, 0, 0, 0, 1, 0);
      step(1, 9, 1, 0, 0, 0, 0, 0);
      step(1, 9, 1, 0, 0, 0, 0, 1);
      nop(1); nop(1); nop(1);

      // r0 writes are neutered and never cause load-use
      step(1, 0, 1, 0, 0, 0, 0, 1);
      step(1, 0, 1, 1, 0, 0, 0, 1);
      step(1, 4, 1, 0, 0, 0, 0, 1);
      nop(1); nop(1); nop(1);

      // back-to-back loads to the same register
      step(1, 7, 1, 1, 0, 0, 0, 1);
      step(1, 7, 1, 1, 1, 2, 0, 1);
      nop(0); nop(0); nop(1);
      nop(0); nop(1); nop(1); nop(1);

      // async reset in the middle of WAIT
      step(1, 5, 1, 1, 0, 0, 0, 1);
      nop(1);
      nop(0); nop(0);
      @(negedge clk); #1;
      chk("pre_reset.mem_wait", int'(bus.mem_wait), int'(m_wait));
      #1 reset = 1'b1;
      #1 check_all_zero("async_reset");
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();

      burst = 0;
      for (int i = 0; i < 800; i++) begin
         if (burst > 0) begin
            rdy = 1'b0;
            burst--;
         end else begin
            rdy = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 60) == 0) burst = 18;
         end
         step($urandom_range(0, 3) != 0, int'($urandom_range(0, 4)),
              $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
              int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
              $urandom_range(0, 9) == 0, rdy);
      end

      @(negedge clk); #1;
      chk("scoreboard_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hazard_pipe_tracker.md
Name: hazard_pipe_tracker

Overview:
- Producer end of the forwarding interface. Tracks destination-register metadata (rd, regWrite, memRead) through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Drives the EX_MEM_* and MEM_WB_* signals consumed by the forwarding unit.
- Detects load-use hazards and inserts bubbles.
- Freezes the pipeline while a load waits on data memory (mem_ready handshake), with a timeout.
- Keeps a saturating stall-cycle counter for performance visibility.

Parameters:
REG_W, 4, register-number width (16 registers; register 0 is hard-wired zero)
MEM_TIMEOUT, 15, maximum consecutive wait cycles on one load before it is abandoned
CNT_W, 16, stall counter width

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
id_valid  input  1  ID stage holds a real instruction
id_rd  input  REG_W  destination register of the ID instruction
id_regWrite  input  1  ID instruction writes the register file
id_memRead  input  1  ID instruction is a load
id_rs  input  REG_W  first source register of the ID instruction
id_rt  input  REG_W  second source register of the ID instruction
flush  input  1  squash the ID instruction (branch taken)
mem_ready  input  1  data memory returns load data this cycle
ID_EX_rd, EX_MEM_rd, MEM_WB_rd  output  REG_W  registered destination numbers
ID_EX_regWrite, EX_MEM_regWrite, MEM_WB_regWrite  output  1  registered write enables
ID_EX_memRead, EX_MEM_memRead  output  1  registered load flags
stall_id  output  1  combinational; hold PC and IF/ID this cycle
mem_wait  output  1  registered; FSM is in WAIT
mem_error  output  1  sticky; a load timed out
stall_count  output  CNT_W  saturating count of cycles with stall_id high

Behaviour:
- Reset (asynchronous): all rd = 0, all regWrite/memRead = 0, state = RUN, wait counter = 0, flush_pend = 0, mem_error = 0, stall_count = 0.
- A bubble is rd = 0, regWrite = 0, memRead = 0.
- An entry with rd == 0 is always stored with regWrite = 0.

FSM states: RUN, WAIT.
- RUN -> WAIT: EX_MEM_memRead == 1 and mem_ready == 0. The pipeline does not advance on this edge. The wait counter loads 1.
- WAIT, mem_ready == 1: return to RUN and advance normally on the same edge.
- WAIT, mem_ready == 0 and wait counter == MEM_TIMEOUT:
  - set mem_error
  - advance, but MEM_WB receives a bubble instead of the load
  - return to RUN
- WAIT otherwise: wait counter increments; all pipeline registers hold.
- freeze = (state == RUN and EX_MEM_memRead and !mem_ready) or (state == WAIT and !mem_ready and counter != MEM_TIMEOUT).

Load-use detection:
- load_use = id_valid and ID_EX_memRead and ID_EX_rd != 0 and (ID_EX_rd == id_rs or ID_EX_rd == id_rt).
- stall_id = freeze or load_use.

Advance rules (priority order):
1. freeze: all stage registers hold. A flush arriving during freeze sets flush_pend.
2. flush or flush_pend: ID/EX takes a bubble; flush_pend clears.
3. load_use: ID/EX takes a bubble; EX/MEM and MEM/WB shift normally.
4. Normal: ID/EX takes the id_* fields, or a bubble if id_valid == 0. EX/MEM <= ID/EX; MEM_WB <= EX/MEM.

Latency and counter:
- Latency is one cycle per stage: an ID instruction appears on EX_MEM_* two advancing edges after acceptance and on MEM_WB_* after three.
- stall_count increments each cycle stall_id == 1 and holds at all-ones.

Boundaries:
- Back-to-back loads to the same register each get an independent wait.
- Reset asserted mid-WAIT aborts immediately to the reset values.
- mem_ready high while EX_MEM_memRead == 0 is ignored.

Decomposition:
- Shared package hazard_pkg: REG_W, ZERO_REG = 0, state encoding (RUN = 1'b0, WAIT = 1'b1), and a pipe_entry record {rd, regWrite, memRead} with a BUBBLE constant.
- One sub-module, pipe_stage_reg: a single stage register with hold and load-bubble controls, instantiated three times.
- The FSM and hazard logic live in the top module.

Test Plan:
1. Load r3 in ID, next ID reads rs = r3, mem_ready = 1 -> stall_id = 1 for one cycle, ID_EX gets a bubble, EX_MEM_rd = 3 with regWrite = 1 two cycles after the load is accepted, stall_count = 1.
2. Load r5 reaches EX/MEM with mem_ready low for 3 cycles -> mem_wait high for 3 cycles, all stage registers frozen, MEM_WB_rd = 5 on the edge where mem_ready rises, stall_count = 3.
3. mem_ready held low with MEM_TIMEOUT = 15 -> after 15 wait cycles mem_error = 1, MEM_WB gets a bubble (MEM_WB_regWrite = 0), state returns to RUN.
4. flush pulsed during WAIT -> no change while frozen; on the first advancing edge ID/EX gets a bubble and the pending ID instruction never reaches EX/MEM.
5. ID instruction writes r0 with id_regWrite = 1 -> stored with regWrite = 0; a subsequent load of r0 followed by a read of r0 produces no load-use stall.
6. reset asserted asynchronously mid-WAIT -> all outputs zero immediately, before the next clock edge.
